// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 register file family.
// Default widths, architectural register indices, and a helper that sizes
// the packed multi-port buses (read selects and read data).
package lc3_pkg;

  // Default register width and index width of the classic LC-3 file.
  localparam int LC3_DATA_W = 16;
  localparam int LC3_ADDR_W = 3;
  localparam int LC3_NUM_RD = 2;

  // Architectural register indices R0..R7.
  localparam logic [2:0] REG_R0 = 3'd0;
  localparam logic [2:0] REG_R1 = 3'd1;
  localparam logic [2:0] REG_R2 = 3'd2;
  localparam logic [2:0] REG_R3 = 3'd3;
  localparam logic [2:0] REG_R4 = 3'd4;
  localparam logic [2:0] REG_R5 = 3'd5;
  localparam logic [2:0] REG_R6 = 3'd6;
  localparam logic [2:0] REG_R7 = 3'd7;

  // Width of a bus that packs n ports of w bits each.
  function automatic int packed_w(input int n, input int w);
    return n * w;
  endfunction

endpackage

// File: rtl/lc3_regfile_rdport.sv
// One read port of the scoreboarded register file.
// Combinational read mux plus the port's contribution to the issue stall.
// Build option: LC3_REGFILE_BYPASS_EN adds write-to-read forwarding, and a
// port that is forwarded this cycle does not count its pending source.
module lc3_regfile_rdport
  import lc3_pkg::*;
#(
  parameter int  DATA_W = LC3_DATA_W,
  parameter int  ADDR_W = LC3_ADDR_W,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic [DATA_W-1:0] i_regs [DEPTH],
  input  logic [DEPTH-1:0]  i_pend,
  input  logic [ADDR_W-1:0] i_sel,
  input  logic              i_use,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_stall
);

  logic w_hit;

`ifdef LC3_REGFILE_BYPASS_EN
  // Forward the writeback value when this port reads the register being written.
  assign w_hit  = i_wr_en && (i_wr_addr == i_sel);
  assign o_data = w_hit ? i_wr_data : i_regs[i_sel];
`else
  // Without forwarding the port always sees the stored value; the writeback
  // signals are deliberately unused here.
  logic w_unused_wr;
  assign w_unused_wr = i_wr_en ^ (^i_wr_addr) ^ (^i_wr_data);
  assign w_hit       = 1'b0;
  assign o_data      = i_regs[i_sel];
`endif

  // A live port whose source is still awaiting writeback blocks issue.
  assign o_stall = i_use & i_pend[i_sel] & ~w_hit;

endmodule

// File: rtl/lc3_regfile_sb.sv
// Parametrised LC-3 register file with a pending-write scoreboard.
// Issue logic reserves a destination (ISSUE/ISSUE_DR); the writeback path
// (BUS/DR/LD_REG) stores the result and releases the reservation. STALL
// blocks issue while any live read port selects a pending register.
// Handshake: ISSUE is a request held by the issuer until ISSUE_ACK; a
// reservation is taken only on a cycle where ISSUE_ACK is 1 (ISSUE & ~STALL).
// Build option: LC3_REGFILE_BYPASS_EN enables write-to-read forwarding,
// removing the extra bubble after writeback.
module lc3_regfile_sb
  import lc3_pkg::*;
#(
  parameter int  DATA_W = LC3_DATA_W,
  parameter int  ADDR_W = LC3_ADDR_W,
  parameter int  NUM_RD = LC3_NUM_RD,
  localparam int DEPTH  = 2 ** ADDR_W
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic [DATA_W-1:0]                   BUS,
  input  logic [ADDR_W-1:0]                   DR,
  input  logic                                LD_REG,
  input  logic [packed_w(NUM_RD, ADDR_W)-1:0] RD_SEL,
  input  logic [NUM_RD-1:0]                   RD_USE,
  output logic [packed_w(NUM_RD, DATA_W)-1:0] RD_OUT,
  input  logic                                ISSUE,
  input  logic [ADDR_W-1:0]                   ISSUE_DR,
  output logic                                STALL,
  output logic                                ISSUE_ACK,
  output logic [DEPTH-1:0]                    PEND
);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;

  logic              w_ld;
  logic              w_ack;
  logic [NUM_RD-1:0] w_port_stall;
  logic [DEPTH-1:0]  w_set_mask;
  logic [DEPTH-1:0]  w_clr_mask;

  // Writeback and issue are both ignored while reset is held.
  assign w_ld  = LD_REG & ~i_Rst;
  assign w_ack = ISSUE & ~STALL & ~i_Rst;

  // Stall depends only on read selects, read-use flags, writeback and state,
  // never on ISSUE itself.
  assign STALL     = |w_port_stall;
  assign ISSUE_ACK = w_ack;
  assign PEND      = r_pend;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    lc3_regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rdport (
      .i_regs    (r_regs),
      .i_pend    (r_pend),
      .i_sel     (RD_SEL[k*ADDR_W +: ADDR_W]),
      .i_use     (RD_USE[k]),
      .i_wr_en   (w_ld),
      .i_wr_addr (DR),
      .i_wr_data (BUS),
      .o_data    (RD_OUT[k*DATA_W +: DATA_W]),
      .o_stall   (w_port_stall[k])
    );
  end

  // Register storage: cleared by reset, one write per cycle from writeback.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_ld) begin
      r_regs[DR] <= BUS;
    end
  end

  // One-hot set (accepted issue) and clear (writeback) masks for the scoreboard.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_ld) begin
      w_clr_mask[DR] = 1'b1;
    end
    if (w_ack) begin
      w_set_mask[ISSUE_DR] = 1'b1;
    end
  end

  // Scoreboard: clear the completing producer, then set the new one so a
  // reservation on the same index wins over its release.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_pend <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
    end
  end

endmodule

// File: tb/tb_lc3_regfile_sb.sv
// Bench for lc3_regfile_sb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
// Works with or without LC3_REGFILE_BYPASS_EN defined.
module tb_lc3_regfile_sb;
  import lc3_pkg::*;

  localparam int DW = 16, AW = 3, NR = 2, DEPTH = 8;
  localparam int DW2 = 32, AW2 = 4, NR2 = 3, DEPTH2 = 16;

`ifdef LC3_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [DW-1:0]    bus;
  logic [AW-1:0]    dr;
  logic             ld;
  logic [NR*AW-1:0] rd_sel;
  logic [NR-1:0]    rd_use;
  logic [NR*DW-1:0] rd_out;
  logic             issue;
  logic [AW-1:0]    issue_dr;
  logic             stall;
  logic             ack;
  logic [DEPTH-1:0] pend;

  lc3_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) u_dut (
    .i_Clk(clk), .i_Rst(rst), .BUS(bus), .DR(dr), .LD_REG(ld),
    .RD_SEL(rd_sel), .RD_USE(rd_use), .RD_OUT(rd_out),
    .ISSUE(issue), .ISSUE_DR(issue_dr), .STALL(stall),
    .ISSUE_ACK(ack), .PEND(pend)
  );

  // ---------------- wide DUT ----------------
  logic [DW2-1:0]     bus2;
  logic [AW2-1:0]     dr2;
  logic               ld2;
  logic [NR2*AW2-1:0] rd_sel2;
  logic [NR2-1:0]     rd_use2;
  logic [NR2*DW2-1:0] rd_out2;
  logic               issue2;
  logic [AW2-1:0]     issue_dr2;
  logic               stall2;
  logic               ack2;
  logic [DEPTH2-1:0]  pend2;

  lc3_regfile_sb #(.DATA_W(DW2), .ADDR_W(AW2), .NUM_RD(NR2)) u_dut2 (
    .i_Clk(clk), .i_Rst(rst), .BUS(bus2), .DR(dr2), .LD_REG(ld2),
    .RD_SEL(rd_sel2), .RD_USE(rd_use2), .RD_OUT(rd_out2),
    .ISSUE(issue2), .ISSUE_DR(issue_dr2), .STALL(stall2),
    .ISSUE_ACK(ack2), .PEND(pend2)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0]    m_regs [DEPTH];
  logic [DEPTH-1:0] m_pend;
  logic             m_ack;

  function automatic logic [AW-1:0] sel_of(input int k);
    return rd_sel[k*AW +: AW];
  endfunction

  function automatic logic hit_of(input int k);
    return BYP && ld && !rst && (sel_of(k) == dr);
  endfunction

  function automatic logic [DW-1:0] exp_out(input int k);
    return hit_of(k) ? bus : m_regs[sel_of(k)];
  endfunction

  function automatic logic exp_stall();
    logic s;
    s = 1'b0;
    for (int k = 0; k < NR; k++) begin
      if (rd_use[k] && m_pend[sel_of(k)] && !hit_of(k)) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic exp_ack();
    return issue && !exp_stall() && !rst;
  endfunction

  // Model state: reset clears everything, otherwise apply writeback then issue.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
      m_pend = '0;
    end else begin
      m_ack = exp_ack();
      if (ld) begin
        m_regs[dr] = bus;
        m_pend[dr] = 1'b0;
      end
      if (m_ack) m_pend[issue_dr] = 1'b1;
    end
  end

  // Every-cycle compare, half a period away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) begin
      check($sformatf("cmp_rd_out%0d", k), 64'(rd_out[k*DW +: DW]), 64'(exp_out(k)));
    end
    check("cmp_stall", 64'(stall), 64'(exp_stall()));
    check("cmp_ack", 64'(ack), 64'(exp_ack()));
    check("cmp_pend", 64'(pend), 64'(m_pend));
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus = 16'hFFFF; dr = REG_R3; ld = 1'b1;
    rd_sel = {REG_R3, REG_R3}; rd_use = 2'b11;
    issue = 1'b1; issue_dr = REG_R1;
    bus2 = '0; dr2 = '0; ld2 = 1'b0; rd_sel2 = '0; rd_use2 = '0;
    issue2 = 1'b0; issue_dr2 = '0;

    // Reset holds everything at zero; writeback and issue are ignored.
    repeat (3) cyc();
    #2;
    check("rst_rd_out", 64'(rd_out), 64'h0);
    check("rst_pend", 64'(pend), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_ack", 64'(ack), 64'h0);
    rst = 1'b0; ld = 1'b0; issue = 1'b0; rd_use = 2'b00;
    cyc(); #2;
    check("rst_ld_ignored", 64'(rd_out[DW-1:0]), 64'h0);

    // Write r5, shared read on both ports the next cycle.
    ld = 1'b1; dr = REG_R5; bus = 16'h1234; rd_sel = {REG_R5, REG_R5};
    cyc(); ld = 1'b0; #2;
    check("wr_port0", 64'(rd_out[DW-1:0]), 64'h1234);
    check("wr_port1", 64'(rd_out[2*DW-1:DW]), 64'h1234);

    // Reserve r2.
    issue = 1'b1; issue_dr = REG_R2; #1;
    check("issue_r2_ack", 64'(ack), 64'h1);
    cyc(); issue = 1'b0; #2;
    check("issue_r2_pend", 64'(pend), 64'h04);

    // Live dependent read of r2 stalls a new issue.
    rd_sel = {REG_R5, REG_R2}; rd_use = 2'b01; issue = 1'b1; issue_dr = REG_R6; #1;
    check("dep_stall", 64'(stall), 64'h1);
    check("dep_ack", 64'(ack), 64'h0);
    cyc(); #1;
    check("dep_no_reserve", 64'(pend), 64'h04);
    rd_use = 2'b00; #1;
    check("nouse_stall", 64'(stall), 64'h0);
    check("nouse_ack", 64'(ack), 64'h1);
    cyc(); issue = 1'b0; #2;
    check("nouse_pend", 64'(pend), 64'h44);

    // Writeback of r2 with a dependent issue waiting.
    ld = 1'b1; dr = REG_R2; bus = 16'h00AA; rd_use = 2'b01; issue = 1'b1; issue_dr = REG_R3; #2;
`ifdef LC3_REGFILE_BYPASS_EN
    check("wb_byp_out", 64'(rd_out[DW-1:0]), 64'h00AA);
    check("wb_byp_stall", 64'(stall), 64'h0);
    check("wb_byp_ack", 64'(ack), 64'h1);
    cyc(); ld = 1'b0; issue = 1'b0; #2;
    check("wb_byp_pend", 64'(pend), 64'h48);
`else
    check("wb_stall", 64'(stall), 64'h1);
    check("wb_ack", 64'(ack), 64'h0);
    check("wb_old_out", 64'(rd_out[DW-1:0]), 64'h0);
    cyc(); ld = 1'b0; #2;
    check("wb_next_stall", 64'(stall), 64'h0);
    check("wb_next_ack", 64'(ack), 64'h1);
    check("wb_next_out", 64'(rd_out[DW-1:0]), 64'h00AA);
    check("wb_next_pend", 64'(pend), 64'h40);
    cyc(); issue = 1'b0; #2;
    check("wb_after_pend", 64'(pend), 64'h48);
`endif

    // Simultaneous set and clear on r4: set wins, data still written.
    rd_use = 2'b00; issue = 1'b1; issue_dr = REG_R4;
    cyc(); #2;
    check("r4_reserved", 64'(pend), 64'h58);
    ld = 1'b1; dr = REG_R4; bus = 16'h4444; rd_sel = {REG_R5, REG_R4}; #1;
    check("setclr_ack", 64'(ack), 64'h1);
    cyc(); ld = 1'b0; issue = 1'b0; #2;
    check("setclr_pend", 64'(pend), 64'h58);
    check("setclr_data", 64'(rd_out[DW-1:0]), 64'h4444);

    // Asynchronous reset mid-cycle clears data and reservations before the next edge.
    ld = 1'b1; dr = REG_R3; bus = 16'hBEEF; rd_sel = {REG_R5, REG_R3};
    cyc(); ld = 1'b0; #1;
    check("beef_written", 64'(rd_out[DW-1:0]), 64'hBEEF);
    rst = 1'b1; #1;
    check("async_rst_out", 64'(rd_out), 64'h0);
    check("async_rst_pend", 64'(pend), 64'h0);
    cyc(); rst = 1'b0;

    // Wide configuration: r15 on all three ports, 16 pending bits.
    ld2 = 1'b1; dr2 = 4'd15; bus2 = 32'hCAFEF00D; rd_sel2 = {4'd15, 4'd15, 4'd15};
    cyc(); ld2 = 1'b0; #2;
    for (int k = 0; k < NR2; k++) begin
      check($sformatf("wide_port%0d", k), 64'(rd_out2[k*DW2 +: DW2]), 64'hCAFEF00D);
    end
    issue2 = 1'b1; issue_dr2 = 4'd15;
    cyc(); issue2 = 1'b0; #2;
    check("wide_pend", 64'(pend2), 64'h8000);

    // Randomized traffic; the negedge compare checks each cycle.
    repeat (3000) begin
      cyc();
      ld       = ($urandom_range(0, 1) == 1);
      dr       = AW'($urandom_range(0, DEPTH - 1));
      bus      = DW'($urandom);
      rd_sel   = NR*AW'($urandom);
      rd_use   = NR'($urandom_range(0, 3));
      issue    = ($urandom_range(0, 2) != 0);
      issue_dr = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
